// File: rtl/ffcp_pkg.sv
// ============================================================================
// Module      : ffcp_pkg
// Description : Shared FFCP types, default geometry and receive classification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ffcp_pkg;

    localparam int FFCP_TYPE_LEN = 2;
    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_SYN = 2'd0;
    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_MSG = 2'd1;
    localparam logic [FFCP_TYPE_LEN-1:0] FFCP_TYPE_ACK = 2'd2;

    localparam int FFCP_INDEX_LEN  = 6;
    localparam int FFCP_WINDOW_LEN = 8;

    typedef enum logic [1:0] {
        CLS_ACCEPT = 2'd0,
        CLS_DUP    = 2'd1,
        CLS_STALE  = 2'd2,
        CLS_DROP   = 2'd3
    } ffcp_cls_e;

    typedef enum logic [1:0] {
        ACK_IDLE    = 2'd0,
        ACK_PENDING = 2'd1,
        ACK_VALID   = 2'd2
    } ffcp_ack_state_e;

endpackage : ffcp_pkg

`default_nettype wire

// File: rtl/ffcp_window_bitmap.sv
// ============================================================================
// Module      : ffcp_window_bitmap
// Description : Receive-slot flops with set/clear/syn-init and a rotated view
//               of the next-state bitmap aligned to a given head slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffcp_window_bitmap
    import ffcp_pkg::*;
#(
    parameter int WINDOW_LEN = FFCP_WINDOW_LEN,
    localparam int SLOT_W    = $clog2(WINDOW_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  syn_init_i,
    input  logic                  set_en_i,
    input  logic [SLOT_W-1:0]     set_slot_i,
    input  logic                  clr_en_i,
    input  logic [SLOT_W-1:0]     clr_slot_i,
    input  logic [SLOT_W-1:0]     rot_i,
    output logic [WINDOW_LEN-1:0] rcv_o,
    output logic [WINDOW_LEN-1:0] rot_next_o
);

    logic [WINDOW_LEN-1:0] rcv_q;
    logic [WINDOW_LEN-1:0] rcv_d;

    always_comb begin
        rcv_d = rcv_q;
        if (syn_init_i) begin
            rcv_d    = '0;
            rcv_d[0] = 1'b1;
        end else begin
            if (clr_en_i) rcv_d[clr_slot_i] = 1'b0;
            if (set_en_i) rcv_d[set_slot_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcv_q <= '0;
        else        rcv_q <= rcv_d;
    end

    // Bit g of the view is the slot that sits g places past the new head.
    for (genvar g = 0; g < WINDOW_LEN; g++) begin : g_rot
        assign rot_next_o[g] = rcv_d[rot_i + SLOT_W'(g)];
    end

    assign rcv_o = rcv_q;

endmodule : ffcp_window_bitmap

`default_nettype wire

// File: rtl/ffcp_rx_window.sv
// ============================================================================
// Module      : ffcp_rx_window
// Description : FFCP receive window tracker: in-order commit, coalesced
//               cumulative + selective acks, duplicate/drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffcp_rx_window
    import ffcp_pkg::*;
#(
    parameter int INDEX_LEN  = FFCP_INDEX_LEN,
    parameter int WINDOW_LEN = FFCP_WINDOW_LEN,
    parameter int ACK_DELAY  = 64,
    parameter int CNT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  syn_i,
    input  logic                  in_valid_i,
    input  logic [INDEX_LEN-1:0]  in_index_i,
    output logic                  commit_valid_o,
    input  logic                  commit_ready_i,
    output logic [INDEX_LEN-1:0]  commit_index_o,
    output logic                  ack_valid_o,
    input  logic                  ack_ready_i,
    output logic [INDEX_LEN-1:0]  ack_head_o,
    output logic [WINDOW_LEN-1:0] ack_bitmap_o,
    output logic [CNT_LEN-1:0]    dup_count_o,
    output logic [CNT_LEN-1:0]    drop_count_o
);

    localparam int SLOT_W = $clog2(WINDOW_LEN);
    localparam int TMR_W  = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [INDEX_LEN-1:0] c_win       = INDEX_LEN'(WINDOW_LEN);
    localparam logic [INDEX_LEN-1:0] c_stale_min = INDEX_LEN'((1 << INDEX_LEN) - WINDOW_LEN);
    localparam logic [TMR_W-1:0]     c_tmr_max   = TMR_W'(ACK_DELAY - 1);

    logic [INDEX_LEN-1:0]  head_q, head_d;
    logic [INDEX_LEN-1:0]  ack_head_q;
    logic [WINDOW_LEN-1:0] ack_bitmap_q;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  repend_q, repend_d;
    ffcp_ack_state_e       state_q, state_d;
    logic [CNT_LEN-1:0]    dup_q, drop_q;

    logic [WINDOW_LEN-1:0] rcv;
    logic [WINDOW_LEN-1:0] rot_next;
    logic [INDEX_LEN-1:0]  off;
    ffcp_cls_e             cls;
    logic                  in_ok, accept, is_dup, is_stale, is_drop;
    logic                  commit_fire, ack_ev, fire;

    assign commit_valid_o = rcv[head_q[SLOT_W-1:0]];
    assign commit_index_o = head_q;

    always_comb begin
        off = in_index_i - head_q;
        cls = CLS_DROP;
        if (off < c_win)             cls = rcv[in_index_i[SLOT_W-1:0]] ? CLS_DUP : CLS_ACCEPT;
        else if (off >= c_stale_min) cls = CLS_STALE;
    end

    assign in_ok       = in_valid_i && !syn_i;
    assign accept      = in_ok && (cls == CLS_ACCEPT);
    assign is_dup      = in_ok && (cls == CLS_DUP);
    assign is_stale    = in_ok && (cls == CLS_STALE);
    assign is_drop     = in_ok && (cls == CLS_DROP);
    assign commit_fire = commit_valid_o && commit_ready_i && !syn_i;
    assign ack_ev      = accept || is_stale || commit_fire;

    always_comb begin
        head_d = head_q;
        if (syn_i)            head_d = '0;
        else if (commit_fire) head_d = head_q + INDEX_LEN'(1);
    end

    ffcp_window_bitmap #(
        .WINDOW_LEN (WINDOW_LEN)
    ) u_bitmap (
        .clk        (clk),
        .rst_n      (rst_n),
        .syn_init_i (syn_i),
        .set_en_i   (accept),
        .set_slot_i (in_index_i[SLOT_W-1:0]),
        .clr_en_i   (commit_fire),
        .clr_slot_i (head_q[SLOT_W-1:0]),
        .rot_i      (head_d[SLOT_W-1:0]),
        .rcv_o      (rcv),
        .rot_next_o (rot_next)
    );

    // repend remembers ack-worthy events that arrive while an ack is on the wire.
    always_comb begin
        state_d  = state_q;
        repend_d = repend_q;
        timer_d  = timer_q;
        fire     = 1'b0;
        if (syn_i) begin
            state_d  = ACK_PENDING;
            repend_d = 1'b0;
            timer_d  = '0;
        end else begin
            case (state_q)
                ACK_IDLE: begin
                    timer_d = '0;
                    if (ack_ev) state_d = ACK_PENDING;
                end
                ACK_PENDING: begin
                    if (!commit_valid_o || (timer_q == c_tmr_max)) begin
                        fire     = 1'b1;
                        state_d  = ACK_VALID;
                        repend_d = ack_ev;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ACK_VALID: begin
                    repend_d = repend_q || ack_ev;
                    if (ack_ready_i) begin
                        state_d  = repend_d ? ACK_PENDING : ACK_IDLE;
                        repend_d = 1'b0;
                    end
                end
                default: state_d = ACK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            state_q      <= ACK_IDLE;
            repend_q     <= 1'b0;
            timer_q      <= '0;
            ack_head_q   <= '0;
            ack_bitmap_q <= '0;
            dup_q        <= '0;
            drop_q       <= '0;
        end else begin
            head_q   <= head_d;
            state_q  <= state_d;
            repend_q <= repend_d;
            timer_q  <= timer_d;
            if (fire) begin
                ack_head_q   <= head_d;
                ack_bitmap_q <= rot_next;
            end
            if ((is_dup || is_stale) && (dup_q != '1)) dup_q  <= dup_q + CNT_LEN'(1);
            if (is_drop && (drop_q != '1))             drop_q <= drop_q + CNT_LEN'(1);
        end
    end

    assign ack_valid_o  = (state_q == ACK_VALID);
    assign ack_head_o   = ack_head_q;
    assign ack_bitmap_o = ack_bitmap_q;
    assign dup_count_o  = dup_q;
    assign drop_count_o = drop_q;

endmodule : ffcp_rx_window

`default_nettype wire

// File: tb/tb_ffcp_rx_window.sv
// ============================================================================
// Module      : tb_ffcp_rx_window
// Description : Directed self-checking bench for ffcp_rx_window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ffcp_rx_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        syn = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_index = '0;
    logic        commit_ready = 1'b0;
    logic        ack_ready = 1'b0;
    logic        commit_valid;
    logic [5:0]  commit_index;
    logic        ack_valid;
    logic [5:0]  ack_head;
    logic [7:0]  ack_bitmap;
    logic [15:0] dup_count;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ffcp_rx_window #(
        .INDEX_LEN  (6),
        .WINDOW_LEN (8),
        .ACK_DELAY  (64),
        .CNT_LEN    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .syn_i          (syn),
        .in_valid_i     (in_valid),
        .in_index_i     (in_index),
        .commit_valid_o (commit_valid),
        .commit_ready_i (commit_ready),
        .commit_index_o (commit_index),
        .ack_valid_o    (ack_valid),
        .ack_ready_i    (ack_ready),
        .ack_head_o     (ack_head),
        .ack_bitmap_o   (ack_bitmap),
        .dup_count_o    (dup_count),
        .drop_count_o   (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        syn = 1'b0; in_valid = 1'b0; commit_ready = 1'b0; ack_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%b want=0", commit_valid); end
        checks++; if (commit_index !== 6'd0) begin failures++; $display("FAIL reset_commit_index got=%0d want=0", commit_index); end
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== 15'd0) begin failures++; $display("FAIL reset_ack got=%b/%0d/%h want=0/0/00", ack_valid, ack_head, ack_bitmap); end
        checks++; if ({dup_count, drop_count} !== 32'd0) begin failures++; $display("FAIL reset_counters got dup=%0d drop=%0d want 0/0", dup_count, drop_count); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b1;
        syn = 1'b1; tick(); syn = 1'b0;
        checks++; if ({commit_valid, commit_index} !== {1'b1, 6'd0}) begin failures++; $display("FAIL inorder_commit0 got=%b/%0d want=1/0", commit_valid, commit_index); end
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_index = 6'(k); tick();
            checks++; if ({commit_valid, commit_index, ack_valid} !== {1'b1, 6'(k), 1'b0}) begin failures++; $display("FAIL inorder_commit%0d got=%b/%0d ack=%b want=1/%0d ack=0", k, commit_valid, commit_index, ack_valid, k); end
        end
        in_valid = 1'b0; tick();
        checks++; if ({commit_valid, ack_valid} !== 2'b00) begin failures++; $display("FAIL inorder_drain got cv=%b av=%b want 0/0", commit_valid, ack_valid); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd4, 8'h00}) begin failures++; $display("FAIL inorder_ack got=%b/%0d/%h want=1/4/00", ack_valid, ack_head, ack_bitmap); end
        tick();
        checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL inorder_single_ack got=%b want=0", ack_valid); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b0;
        in_valid = 1'b1; in_index = 6'd2; tick();
        checks++; if ({commit_valid, ack_valid} !== 2'b00) begin failures++; $display("FAIL ooo_first got cv=%b av=%b want 0/0", commit_valid, ack_valid); end
        in_index = 6'd1; tick(); in_valid = 1'b0;
        checks++; if ({commit_valid, ack_valid, ack_head, ack_bitmap} !== {1'b0, 1'b1, 6'd0, 8'h06}) begin failures++; $display("FAIL ooo_ack got cv=%b %b/%0d/%h want cv=0 1/0/06", commit_valid, ack_valid, ack_head, ack_bitmap); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd0, 8'h06}) begin failures++; $display("FAIL ooo_ack_hold got=%b/%0d/%h want=1/0/06", ack_valid, ack_head, ack_bitmap); end
    endtask

    task automatic test_forced_ack();
        do_reset();
        commit_ready = 1'b0; ack_ready = 1'b0;
        syn = 1'b1; tick(); syn = 1'b0;
        repeat (63) tick();
        checks++; if ({ack_valid, commit_valid} !== 2'b01) begin failures++; $display("FAIL forced_early got av=%b cv=%b want 0/1", ack_valid, commit_valid); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd0, 8'h01}) begin failures++; $display("FAIL forced_ack got=%b/%0d/%h want=1/0/01", ack_valid, ack_head, ack_bitmap); end
    endtask

    task automatic test_duplicates();
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b1;
        syn = 1'b1; tick(); syn = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_index = 6'(k); tick();
        end
        in_valid = 1'b0; tick();
        checks++; if ({commit_valid, commit_index} !== {1'b0, 6'd5}) begin failures++; $display("FAIL dup_head5 got=%b/%0d want=0/5", commit_valid, commit_index); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd5, 8'h00}) begin failures++; $display("FAIL dup_ack_head5 got=%b/%0d/%h want=1/5/00", ack_valid, ack_head, ack_bitmap); end
        tick();
        in_valid = 1'b1; in_index = 6'd3; tick(); in_valid = 1'b0;
        checks++; if ({dup_count, drop_count} !== {16'd1, 16'd0}) begin failures++; $display("FAIL dup_stale_count got dup=%0d drop=%0d want 1/0", dup_count, drop_count); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd5, 8'h00}) begin failures++; $display("FAIL dup_resend got=%b/%0d/%h want=1/5/00", ack_valid, ack_head, ack_bitmap); end
        in_valid = 1'b1; in_index = 6'd13; tick(); in_valid = 1'b0;
        checks++; if ({dup_count, drop_count, ack_valid} !== {16'd1, 16'd1, 1'b0}) begin failures++; $display("FAIL dup_drop got dup=%0d drop=%0d av=%b want 1/1/0", dup_count, drop_count, ack_valid); end
        tick();
        checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL dup_drop_no_ack got=%b want=0", ack_valid); end
        commit_ready = 1'b0;
        in_valid = 1'b1; in_index = 6'd7; tick();
        tick(); in_valid = 1'b0;
        checks++; if ({dup_count, ack_valid, ack_head, ack_bitmap} !== {16'd2, 1'b1, 6'd5, 8'h04}) begin failures++; $display("FAIL dup_true got dup=%0d %b/%0d/%h want 2 1/5/04", dup_count, ack_valid, ack_head, ack_bitmap); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b1;
        syn = 1'b1; tick(); syn = 1'b0;
        for (int j = 1; j <= 65; j++) begin
            in_valid = 1'b1; in_index = 6'(j); tick();
            checks++; if ({commit_valid, commit_index} !== {1'b1, 6'(j)}) begin failures++; $display("FAIL wrap_commit step=%0d got=%b/%0d want=1/%0d", j, commit_valid, commit_index, 6'(j)); end
        end
        in_valid = 1'b0; tick();
        checks++; if ({commit_valid, commit_index} !== {1'b0, 6'd2}) begin failures++; $display("FAIL wrap_head got=%b/%0d want=0/2", commit_valid, commit_index); end
        n = 0;
        while (!(ack_valid === 1'b1 && ack_head === 6'd2) && n < 20) begin
            tick(); n++;
        end
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd2, 8'h00}) begin failures++; $display("FAIL wrap_ack got=%b/%0d/%h want=1/2/00", ack_valid, ack_head, ack_bitmap); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [3] = '{6'd3, 6'd1, 6'd2};
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b0;
        syn = 1'b1; tick(); syn = 1'b0;
        tick();
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd1, 8'h00}) begin failures++; $display("FAIL bp_first got=%b/%0d/%h want=1/1/00", ack_valid, ack_head, ack_bitmap); end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 3);
            in_index = (c < 3) ? seq[c] : 6'd0;
            tick();
            checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd1, 8'h00}) begin failures++; $display("FAIL bp_stable cyc=%0d got=%b/%0d/%h want=1/1/00", c, ack_valid, ack_head, ack_bitmap); end
        end
        in_valid = 1'b0; ack_ready = 1'b1; tick();
        checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", ack_valid); end
        ack_ready = 1'b0; tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap, commit_index} !== {1'b1, 6'd4, 8'h00, 6'd4}) begin failures++; $display("FAIL bp_second got=%b/%0d/%h ci=%0d want=1/4/00 ci=4", ack_valid, ack_head, ack_bitmap, commit_index); end
    endtask

    task automatic test_syn_mid();
        do_reset();
        commit_ready = 1'b0; ack_ready = 1'b0;
        in_valid = 1'b1; in_index = 6'd20; tick();
        checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL syn_pre_drop got=%0d want=1", drop_count); end
        in_index = 6'd3; tick();
        in_index = 6'd5; tick(); in_valid = 1'b0;
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd0, 8'h28}) begin failures++; $display("FAIL syn_pre_ack got=%b/%0d/%h want=1/0/28", ack_valid, ack_head, ack_bitmap); end
        syn = 1'b1; tick(); syn = 1'b0;
        checks++; if ({ack_valid, commit_valid, commit_index, drop_count} !== {1'b0, 1'b1, 6'd0, 16'd1}) begin failures++; $display("FAIL syn_state got av=%b cv=%b ci=%0d drop=%0d want 0/1/0/1", ack_valid, commit_valid, commit_index, drop_count); end
        commit_ready = 1'b1; ack_ready = 1'b1; tick();
        checks++; if ({commit_valid, commit_index} !== {1'b0, 6'd1}) begin failures++; $display("FAIL syn_commit got=%b/%0d want=0/1", commit_valid, commit_index); end
        tick();
        checks++; if ({ack_valid, ack_head, ack_bitmap} !== {1'b1, 6'd1, 8'h00}) begin failures++; $display("FAIL syn_ack got=%b/%0d/%h want=1/1/00", ack_valid, ack_head, ack_bitmap); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        commit_ready = 1'b1; ack_ready = 1'b0;
        syn = 1'b1; tick(); syn = 1'b0;
        in_valid = 1'b1; in_index = 6'd0; tick();
        in_index = 6'd2; tick(); in_valid = 1'b0;
        checks++; if ({dup_count, ack_valid, ack_head, ack_bitmap, commit_index} !== {16'd1, 1'b1, 6'd1, 8'h02, 6'd1}) begin failures++; $display("FAIL rstmid_pre got dup=%0d %b/%0d/%h ci=%0d want 1 1/1/02 ci=1", dup_count, ack_valid, ack_head, ack_bitmap, commit_index); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({commit_valid, commit_index, ack_valid, ack_head, ack_bitmap, dup_count, drop_count} !== 54'd0) begin failures++; $display("FAIL rstmid_zero got cv=%b ci=%0d av=%b ah=%0d bm=%h dup=%0d drop=%0d want all 0", commit_valid, commit_index, ack_valid, ack_head, ack_bitmap, dup_count, drop_count); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_forced_ack();
        test_duplicates();
        test_wrap();
        test_back_to_back();
        test_syn_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ffcp_rx_window

`default_nettype wire
